branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of in-flight prediction entries (power of two, 2..16).
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush is held (1..15).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pred_valid  input  1  fetch pushes one predicted branch this cycle.
REQ-006 pred_taken  input  1  predicted direction of the pushed branch.
REQ-007 pred_target  input  32  predicted target of the pushed branch.
REQ-008 pred_fallthru  input  32  sequential PC (branch PC + 4) of the pushed branch.
REQ-009 pred_ready  output  1  an entry can be accepted this cycle.
REQ-010 res_valid  input  1  execute resolves the oldest in-flight branch this cycle.
REQ-011 res_taken  input  1  actual direction.
REQ-012 res_target  input  32  actual taken target.
REQ-013 upd_valid  output  1  one-cycle pulse driving the predictor's branch_inst input.
REQ-014 upd_taken  output  1  actual direction, driving the predictor's branch_h input.
REQ-015 upd_target  output  32  actual target, driving the predictor's pc_branch input.
REQ-016 flush  output  1  squash younger fetched instructions.
REQ-017 redirect_pc  output  32  corrected fetch PC; valid while flush=1.
REQ-018 mispredict_cnt  output  16  saturating count of mispredictions.
REQ-019 err_underflow  output  1  one-cycle pulse when res_valid arrives with the queue empty.

Function
REQ-020 The block SHALL hold predictions in an in-order FIFO of DEPTH entries of {pred_taken, pred_target, pred_fallthru}.
REQ-021 A push SHALL occur when pred_valid=1 and pred_ready=1; pred_ready SHALL be 1 only in state RUN with count<DEPTH, and SHALL NOT depend on a same-cycle pop.
REQ-022 A pop SHALL occur when res_valid=1, state is RUN and count>0; a resolution always pairs with the head entry.
REQ-023 A simultaneous push and pop without misprediction SHALL leave count unchanged, with both pointers advancing and wrapping modulo DEPTH.
REQ-024 A misprediction SHALL be declared on a pop when res_taken!=head.taken, or when res_taken=1, head.taken=1 and res_target!=head.target.
REQ-025 FSM states: RUN, FLUSH; RUN->FLUSH on a mispredicting pop; FLUSH->RUN after FLUSH_CYCLES cycles, timed by a down-counter.
REQ-026 flush SHALL be registered and equal 1 exactly during the FLUSH state, i.e. from cycle N+1 to N+FLUSH_CYCLES for a mispredicting pop in cycle N.
REQ-027 redirect_pc SHALL be loaded at the mispredicting pop with res_target if res_taken=1, else head.fallthru, and held until the next misprediction.
REQ-028 On a mispredicting pop the FIFO SHALL be cleared (count=0, pointers=0), and any same-cycle push SHALL be discarded.
REQ-029 In FLUSH, pred_valid and res_valid SHALL be ignored, with no push, pop, update or err_underflow.
REQ-030 For every pop in cycle N, upd_valid SHALL be 1 in cycle N+1 with upd_taken=res_taken and upd_target=res_target, whether or not it mispredicted; otherwise upd_valid=0.
REQ-031 upd_taken and upd_target SHALL hold their last values while upd_valid=0.
REQ-032 mispredict_cnt SHALL increment by 1 in cycle N+1 for each misprediction in cycle N, and saturate at 16'hFFFF.
REQ-033 res_valid=1 in RUN with count=0 SHALL pulse err_underflow in cycle N+1 and change no other state.

Reset
REQ-034 While rst=1, the block SHALL set state=RUN, count=0, both pointers=0, pred_ready=0, upd_valid=0, upd_taken=0, upd_target=0, flush=0, redirect_pc=0, mispredict_cnt=0 and err_underflow=0; pred_ready SHALL go to 1 in the first cycle after rst deasserts.
REQ-035 Reset asserted during FLUSH or with entries in flight SHALL abandon them with no update or flush pulse afterwards.

Verification
REQ-036 Push {taken=1, target=0x100, fallthru=0x14}, then resolve {taken=1, target=0x100} -> next cycle upd_valid=1, upd_taken=1, upd_target=0x100, flush=0, mispredict_cnt=0.
REQ-037 Push {taken=0, fallthru=0x24}, resolve {taken=1, target=0x200} -> flush=1 for exactly 2 cycles, redirect_pc=0x200, mispredict_cnt=1, pred_ready=0 during flush, queue empty afterwards.
REQ-038 Push {taken=1, target=0x300, fallthru=0x34}, resolve {taken=0} -> redirect_pc=0x34; same entry resolved {taken=1, target=0x304} instead -> misprediction, redirect_pc=0x304.
REQ-039 Push 4 entries -> pred_ready=0; a 5th push plus a same-cycle correct pop -> 5th dropped, count=3; next cycle pred_ready=1; 6 further push/pop pairs exercise pointer wrap in order.
REQ-040 res_valid with queue empty -> err_underflow pulse, no upd_valid; res_valid during FLUSH -> ignored.
REQ-041 Preload mispredict_cnt to 0xFFFF via 65535 mispredicts, one more -> stays 0xFFFF; assert rst mid-FLUSH -> flush=0 and pred_ready=1 one cycle after release.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: pairs in-order branch predictions with execute resolutions, drives predictor updates and fetch redirects
module branch_resolve #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic [31:0] pred_fallthru,
    output logic        pred_ready,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        upd_valid,
    output logic        upd_taken,
    output logic [31:0] upd_target,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [15:0] mispredict_cnt,
    output logic        err_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] fallthru;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    state_t        state_q;
    logic [3:0]    flush_cnt_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic          upd_valid_q, upd_taken_q, err_q;
    logic [31:0]   upd_target_q, redirect_q;
    logic [15:0]   mis_cnt_q;
    logic          push, pop, mis, underflow;
    entry_t        head;

    assign pred_ready     = !rst && state_q == RUN && cnt_q != FULL;
    assign upd_valid      = upd_valid_q;
    assign upd_taken      = upd_taken_q;
    assign upd_target     = upd_target_q;
    assign flush          = state_q == FLUSH;
    assign redirect_pc    = redirect_q;
    assign mispredict_cnt = mis_cnt_q;
    assign err_underflow  = err_q;

    // Decode this cycle's push/pop and whether the popped head was mispredicted
    always_comb begin
        head      = fifo_q[rd_ptr_q];
        push      = pred_valid && pred_ready;
        pop       = res_valid && state_q == RUN && cnt_q != '0;
        underflow = res_valid && state_q == RUN && cnt_q == '0;
        mis       = pop && ((res_taken != head.taken) ||
                            (res_taken && head.taken && res_target != head.target));
        cnt_d     = mis ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    // Control state: queue pointers, flush sequencing, update/redirect outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_cnt_q  <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            upd_target_q <= '0;
            redirect_q   <= '0;
            mis_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            upd_valid_q <= pop;
            err_q       <= underflow;
            cnt_q       <= cnt_d;
            if (pop) begin
                upd_taken_q  <= res_taken;
                upd_target_q <= res_target;
            end
            if (mis) begin
                state_q     <= FLUSH;
                flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                redirect_q  <= res_taken ? res_target : head.fallthru;
                if (mis_cnt_q != 16'hFFFF) mis_cnt_q <= mis_cnt_q + 16'd1;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
                if (state_q == FLUSH) begin
                    if (flush_cnt_q == '0) state_q <= RUN;
                    else flush_cnt_q <= flush_cnt_q - 4'd1;
                end
            end
        end
    end

    // Entry storage; a push coinciding with a mispredict is squashed
    always_ff @(posedge clk) begin
        if (push && !mis) fifo_q[wr_ptr_q] <= {pred_taken, pred_target, pred_fallthru};
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed self-checking bench for branch_resolve (DEPTH=4, FLUSH_CYCLES=2)
module tb_branch_resolve;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0, pred_taken = 1'b0;
    logic [31:0] pred_target = '0, pred_fallthru = '0;
    logic        pred_ready;
    logic        res_valid = 1'b0, res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        upd_valid, upd_taken, flush, err_underflow;
    logic [31:0] upd_target, redirect_pc;
    logic [15:0] mispredict_cnt;
    int          checks = 0;
    int          failures = 0;

    branch_resolve #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_fallthru(pred_fallthru),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_target(upd_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .mispredict_cnt(mispredict_cnt), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] tgt(input int i);
        return 32'h1000 + 32'(i) * 32'd16;
    endfunction

    task automatic push_e(input int i);
        pred_valid    = 1'b1;
        pred_taken    = i[0];
        pred_target   = tgt(i);
        pred_fallthru = 32'h2000 + 32'(i) * 32'd4;
    endtask

    task automatic resolve_e(input int i);
        res_valid  = 1'b1;
        res_taken  = i[0];
        res_target = tgt(i);
    endtask

    task automatic set_pred(input logic t, input logic [31:0] tg, input logic [31:0] ft);
        pred_valid = 1'b1; pred_taken = t; pred_target = tg; pred_fallthru = ft;
    endtask

    task automatic set_res(input logic t, input logic [31:0] tg);
        res_valid = 1'b1; res_taken = t; res_target = tg;
    endtask

    initial begin
        tick(); tick();
        chk("rst_ready", 32'(pred_ready), 32'd0);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_upd_target", upd_target, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_mcnt", 32'(mispredict_cnt), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(pred_ready), 32'd1);

        // Correct taken prediction
        set_pred(1'b1, 32'h100, 32'h14); tick(); pred_valid = 1'b0;
        set_res(1'b1, 32'h100); tick(); res_valid = 1'b0;
        chk("t1_upd_valid", 32'(upd_valid), 32'd1);
        chk("t1_upd_taken", 32'(upd_taken), 32'd1);
        chk("t1_upd_target", upd_target, 32'h100);
        chk("t1_flush", 32'(flush), 32'd0);
        chk("t1_mcnt", 32'(mispredict_cnt), 32'd0);
        tick();
        chk("t1_upd_valid_off", 32'(upd_valid), 32'd0);
        chk("t1_upd_target_hold", upd_target, 32'h100);
        chk("t1_upd_taken_hold", 32'(upd_taken), 32'd1);

        // Not-taken predicted, actually taken; inputs during flush ignored
        set_pred(1'b0, 32'h999, 32'h24); tick(); pred_valid = 1'b0;
        set_res(1'b1, 32'h200); tick();
        chk("t2_flush_c1", 32'(flush), 32'd1);
        chk("t2_redirect", redirect_pc, 32'h200);
        chk("t2_mcnt", 32'(mispredict_cnt), 32'd1);
        chk("t2_ready_flush", 32'(pred_ready), 32'd0);
        chk("t2_upd_valid", 32'(upd_valid), 32'd1);
        set_pred(1'b1, 32'h777, 32'h78); tick();
        chk("t2_flush_c2", 32'(flush), 32'd1);
        chk("t2_ign_upd", 32'(upd_valid), 32'd0);
        chk("t2_ign_err", 32'(err_underflow), 32'd0);
        pred_valid = 1'b0; res_valid = 1'b0; tick();
        chk("t2_flush_end", 32'(flush), 32'd0);
        chk("t2_ready_back", 32'(pred_ready), 32'd1);
        set_res(1'b0, 32'h0); tick();
        chk("t2_empty_err", 32'(err_underflow), 32'd1);
        chk("t2_empty_upd", 32'(upd_valid), 32'd0);
        res_valid = 1'b0; tick();
        chk("t2_err_pulse", 32'(err_underflow), 32'd0);
        chk("t2_redirect_hold", redirect_pc, 32'h200);
        chk("t2_mcnt_hold", 32'(mispredict_cnt), 32'd1);

        // Taken predicted, not taken -> fallthrough redirect
        set_pred(1'b1, 32'h300, 32'h34); tick(); pred_valid = 1'b0;
        set_res(1'b0, 32'h0); tick(); res_valid = 1'b0;
        chk("t3a_redirect", redirect_pc, 32'h34);
        chk("t3a_mcnt", 32'(mispredict_cnt), 32'd2);
        chk("t3a_flush", 32'(flush), 32'd1);
        tick(); tick();
        chk("t3a_flush_end", 32'(flush), 32'd0);
        // Taken both ways but wrong target
        set_pred(1'b1, 32'h300, 32'h34); tick(); pred_valid = 1'b0;
        set_res(1'b1, 32'h304); tick(); res_valid = 1'b0;
        chk("t3b_redirect", redirect_pc, 32'h304);
        chk("t3b_mcnt", 32'(mispredict_cnt), 32'd3);
        chk("t3b_upd_target", upd_target, 32'h304);
        tick(); tick();
        chk("t3b_flush_end", 32'(flush), 32'd0);

        // Fill, full push dropped, then wrap with pairs; a misordered pop would mispredict
        for (int i = 0; i < 4; i++) begin
            push_e(i); tick();
        end
        pred_valid = 1'b0;
        chk("t4_full_ready", 32'(pred_ready), 32'd0);
        push_e(4); resolve_e(0); tick();
        chk("t4_pop0_upd", 32'(upd_valid), 32'd1);
        chk("t4_pop0_tgt", upd_target, tgt(0));
        chk("t4_ready_again", 32'(pred_ready), 32'd1);
        chk("t4_pop0_flush", 32'(flush), 32'd0);
        begin
            int pops [6] = '{1, 2, 3, 5, 6, 7};
            for (int k = 0; k < 6; k++) begin
                push_e(5 + k); resolve_e(pops[k]); tick();
                chk("t4_pair_upd", 32'(upd_valid), 32'd1);
                chk("t4_pair_tgt", upd_target, tgt(pops[k]));
                chk("t4_pair_flush", 32'(flush), 32'd0);
            end
        end
        pred_valid = 1'b0;
        for (int i = 8; i < 11; i++) begin
            resolve_e(i); tick();
            chk("t4_drain_tgt", upd_target, tgt(i));
            chk("t4_drain_flush", 32'(flush), 32'd0);
        end
        set_res(1'b0, 32'h0); tick(); res_valid = 1'b0;
        chk("t4_count3_err", 32'(err_underflow), 32'd1);
        chk("t4_mcnt", 32'(mispredict_cnt), 32'd3);

        // Preload the counter just below saturation, then two more mispredicts
        force dut.mis_cnt_q = 16'hFFFE;
        tick();
        release dut.mis_cnt_q;
        set_pred(1'b0, 32'h0, 32'h44); tick(); pred_valid = 1'b0;
        set_res(1'b1, 32'h500); tick(); res_valid = 1'b0;
        chk("t5_mcnt_max", 32'(mispredict_cnt), 32'hFFFF);
        chk("t5_redirect", redirect_pc, 32'h500);
        tick(); tick();
        set_pred(1'b0, 32'h0, 32'h48); tick(); pred_valid = 1'b0;
        set_res(1'b1, 32'h600); tick(); res_valid = 1'b0;
        chk("t5_mcnt_sat", 32'(mispredict_cnt), 32'hFFFF);
        chk("t5_flush", 32'(flush), 32'd1);
        rst = 1'b1; tick();
        chk("t5_rst_flush", 32'(flush), 32'd0);
        chk("t5_rst_ready", 32'(pred_ready), 32'd0);
        chk("t5_rst_mcnt", 32'(mispredict_cnt), 32'd0);
        chk("t5_rst_redirect", redirect_pc, 32'd0);
        rst = 1'b0; #1;
        chk("t5_ready_release", 32'(pred_ready), 32'd1);
        tick();
        chk("t5_no_flush", 32'(flush), 32'd0);
        chk("t5_no_upd", 32'(upd_valid), 32'd0);

        // Reset with an entry in flight abandons it
        push_e(3); tick(); pred_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        set_res(1'b1, tgt(3)); tick(); res_valid = 1'b0;
        chk("t6_abandon_err", 32'(err_underflow), 32'd1);
        chk("t6_abandon_upd", 32'(upd_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
